flag_ctrl: RTL and testbench
============================

// Module: flag_ctrl
// PURPOSE
//  Owns the architectural NZCV flag register fed by the ALU's negative/zero/overflow/carryOut outputs.
//  Sequences flag updates from the EX stage through a one-deep pending stage into the committed register.
//  Resolves branch conditions (B, CBZ, CBNZ, B.cond) and interlocks the branch when flags are not yet valid.
//  Sits beside the EX-stage ALU; its taken/ready outputs drive the fetch redirect and the hazard unit.
// PARAMETERS
//  FWD_EN  1  1: forward in-flight flags to the branch resolver; 0: stall the branch until flags commit
//  COND_W  4  width of the B.cond condition field
// PORTS
//  clk           in   1       system clock; all state updates on posedge
//  reset         in   1       synchronous, active-high; wins over every other input
//  stall         in   1       global pipeline freeze; all state holds
//  flush         in   1       kills the current EX instruction (no flag capture)
//  ex_valid      in   1       EX stage holds a real instruction
//  ex_set_flags  in   1       EX instruction is a flag-setting op (ADDS/SUBS/ANDS...)
//  ex_negative   in   1       ALU negative flag
//  ex_zero       in   1       ALU zero flag
//  ex_carry      in   1       ALU carryOut flag
//  ex_overflow   in   1       ALU overflow flag
//  br_valid      in   1       a branch is requesting resolution this cycle
//  br_kind       in   2       00 B, 01 CBZ, 10 CBNZ, 11 B.cond
//  br_cond       in   COND_W  condition code for B.cond
//  br_reg_zero   in   1       tested register == 0 (CBZ/CBNZ)
//  br_ready      out  1       branch may resolve this cycle
//  br_taken      out  1       branch resolves taken (qualified by br_valid & br_ready)
//  flags_q       out  4       committed {N,Z,C,V}
//  flags_fwd     out  4       flags seen by the resolver
// BEHAVIOUR
//  Registers: flags_q[3:0], pend_v, pend_flags[3:0]. Reset: all 0, so every output is 0 except
//   br_ready (1 when FWD_EN=1, or when FWD_EN=0 and no flag update is in flight).
//  ex_upd = ex_valid & ex_set_flags & ~flush (combinational).
//  Posedge priority: reset > stall (hold all) > normal.
//  Normal: pend_v <= ex_upd; pend_flags <= {ex_negative,ex_zero,ex_carry,ex_overflow};
//   if pend_v then flags_q <= pend_flags. Capture and commit on the same edge are legal and both occur.
//  Latency: EX flags are visible in flags_q 2 edges later (unstalled). Each stall cycle adds 1.
//  flags_fwd, FWD_EN=1: ex_upd ? EX flags : pend_v ? pend_flags : flags_q (youngest wins).
//  flags_fwd, FWD_EN=0: flags_q.
//  br_ready: FWD_EN=1 -> 1; FWD_EN=0 -> ~(ex_upd | pend_v). Branch holds its inputs until ready.
//  br_taken = br_valid & br_ready & cond_true.
//   kind 00 -> 1; 01 -> br_reg_zero; 10 -> ~br_reg_zero; 11 -> cond table on flags_fwd.
//  Cond table: 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V;
//   8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E,F always.
//  CBZ/CBNZ/B never depend on the flags, so br_ready is forced to 1 for kinds 00-10 in both modes.
//  flush & stall in the same cycle: state holds; EX is excluded from flags_fwd/br_ready.
//  Reset mid-update drops the pending entry; flags_q returns to 0.
//  Outputs are combinational from state and current inputs; no output is registered.
// STRUCTURE
//  cpu_pkg: flags_t packed struct {n,z,c,v}; br_kind_e enum; COND_* localparams (EQ..NV).
//  Sub-module cond_eval (combinational: cond, flags_t -> taken). Reused later by CSEL/CSINC.
// TESTING
//  Reset: assert reset 2 cycles with ex_upd=1 -> flags_q=0, pend_v=0; br_ready=1 (FWD_EN=1).
//  Commit latency: SUBS with Z=1 at cycle 0 -> flags_q=4'b0100 after edge 2; a stall at cycle 1 moves it to edge 3.
//  Forwarding (FWD_EN=1): EX SUBS Z=1 plus B.cond EQ in the same cycle -> br_ready=1, br_taken=1.
//   Same test with flush=1 -> br_taken uses flags_q (0) -> 0.
//  Interlock (FWD_EN=0): SUBS then B.cond NE -> br_ready=0 for 2 cycles, then 1 with br_taken
//   per flags_q. CBZ with br_reg_zero=1 during the interlock -> ready=1, taken=1.
//  Cond table sweep: all 16 codes x 16 NZCV values vs a reference model; e.g. N=1,V=0 -> LT=1, GE=0, GT=0, LE=1.
//  Back-to-back: ADDS N=1, then ANDS Z=1 on consecutive cycles -> flags_fwd shows the younger (Z);
//   flags_q = 4'b1000 then 4'b0100.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: NZCV flag layout, branch kinds and B.cond condition codes.
// Consumed by the flag controller and by the condition evaluator.
package cpu_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_CBZ  = 2'b01,
        BR_CBNZ = 2'b10,
        BR_COND = 2'b11
    } br_kind_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM-style condition evaluator: condition code + NZCV -> taken.
// Kept standalone so conditional-select ops can share it.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b1;
        unique case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = ~flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = ~flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = ~flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = ~flags.v;
            COND_HI: taken = flags.c & ~flags.z;
            COND_LS: taken = ~flags.c | flags.z;
            COND_GE: taken = (flags.n == flags.v);
            COND_LT: taken = (flags.n != flags.v);
            COND_GT: taken = ~flags.z & (flags.n == flags.v);
            COND_LE: taken = flags.z | (flags.n != flags.v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// NZCV flag register with a one-deep pending stage between EX and commit,
// plus branch resolution with optional forwarding of in-flight flags.
module flag_ctrl
    import cpu_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int COND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic              ex_carry,
    input  logic              ex_overflow,
    input  logic              br_valid,
    input  logic [1:0]        br_kind,
    input  logic [COND_W-1:0] br_cond,
    input  logic              br_reg_zero,
    output logic              br_ready,
    output logic              br_taken,
    output logic [3:0]        flags_q,
    output logic [3:0]        flags_fwd
);

    flags_t   ex_flags;
    flags_t   commit_q, commit_d;
    flags_t   pend_flags_q, pend_flags_d;
    flags_t   fwd_flags;
    logic     pend_v_q, pend_v_d;
    logic     ex_upd;
    logic     cond_true;
    logic     flag_taken;
    br_kind_e kind;

    // Reset masks EX so that every output reads idle while reset is held.
    assign ex_upd   = ex_valid & ex_set_flags & ~flush & ~reset;
    assign ex_flags = {ex_negative, ex_zero, ex_carry, ex_overflow};
    assign kind     = br_kind_e'(br_kind);

    always_comb begin
        commit_d     = commit_q;
        pend_v_d     = pend_v_q;
        pend_flags_d = pend_flags_q;
        if (!stall) begin
            pend_v_d     = ex_upd;
            pend_flags_d = ex_flags;
            if (pend_v_q) begin
                commit_d = pend_flags_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_q     <= '0;
            pend_v_q     <= 1'b0;
            pend_flags_q <= '0;
        end else begin
            commit_q     <= commit_d;
            pend_v_q     <= pend_v_d;
            pend_flags_q <= pend_flags_d;
        end
    end

    // Youngest producer wins: EX, then the pending stage, then the committed value.
    always_comb begin
        fwd_flags = commit_q;
        if (FWD_EN) begin
            if (ex_upd) begin
                fwd_flags = ex_flags;
            end else if (pend_v_q) begin
                fwd_flags = pend_flags_q;
            end
        end
    end

    cond_eval u_cond_eval (
        .cond  (br_cond[3:0]),
        .flags (fwd_flags),
        .taken (flag_taken)
    );

    always_comb begin
        cond_true = 1'b1;
        br_ready  = 1'b1;
        unique case (kind)
            BR_B:    cond_true = 1'b1;
            BR_CBZ:  cond_true = br_reg_zero;
            BR_CBNZ: cond_true = ~br_reg_zero;
            BR_COND: begin
                cond_true = flag_taken;
                br_ready  = FWD_EN | ~(ex_upd | pend_v_q);
            end
            default: cond_true = 1'b1;
        endcase
    end

    assign br_taken  = br_valid & br_ready & cond_true;
    assign flags_q   = commit_q;
    assign flags_fwd = fwd_flags;

endmodule

// File: tb/tb_flag_ctrl.sv
// Bench for flag_ctrl: one forwarding and one interlocking instance share stimulus;
// a reference model predicts outputs that travel through an expected queue.
module tb_flag_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall, flush;
    logic       ex_valid, ex_set_flags;
    logic       ex_negative, ex_zero, ex_carry, ex_overflow;
    logic       br_valid;
    logic [1:0] br_kind;
    logic [3:0] br_cond;
    logic       br_reg_zero;

    logic       rdy1, tak1, rdy0, tak0;
    logic [3:0] q1, fwd1, q0, fwd0;

    logic [3:0] m_commit, m_pend;
    logic       m_pv;
    logic [19:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flag_ctrl #(.FWD_EN(1'b1), .COND_W(4)) u_fwd (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_negative(ex_negative), .ex_zero(ex_zero),
        .ex_carry(ex_carry), .ex_overflow(ex_overflow),
        .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
        .br_reg_zero(br_reg_zero),
        .br_ready(rdy1), .br_taken(tak1), .flags_q(q1), .flags_fwd(fwd1)
    );

    flag_ctrl #(.FWD_EN(1'b0), .COND_W(4)) u_stl (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_negative(ex_negative), .ex_zero(ex_zero),
        .ex_carry(ex_carry), .ex_overflow(ex_overflow),
        .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
        .br_reg_zero(br_reg_zero),
        .br_ready(rdy0), .br_taken(tak0), .flags_q(q0), .flags_fwd(fwd0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Pairs of codes share a base predicate; the odd code of each pair is its inverse.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [9:0] predict(input logic fwd_mode);
        logic       upd, rdy, ct;
        logic [3:0] exf, f;
        upd = ex_valid & ex_set_flags & ~flush & ~reset;
        exf = {ex_negative, ex_zero, ex_carry, ex_overflow};
        if (fwd_mode) f = upd ? exf : (m_pv ? m_pend : m_commit);
        else          f = m_commit;
        rdy = 1'b1;
        case (br_kind)
            2'd0: ct = 1'b1;
            2'd1: ct = br_reg_zero;
            2'd2: ct = ~br_reg_zero;
            default: begin
                ct  = cond_ref(br_cond, f);
                rdy = fwd_mode ? 1'b1 : ~(upd | m_pv);
            end
        endcase
        return {rdy, br_valid & rdy & ct, f, m_commit};
    endfunction

    task automatic idle();
        stall = 0; flush = 0; ex_valid = 0; ex_set_flags = 0;
        {ex_negative, ex_zero, ex_carry, ex_overflow} = 4'b0;
        br_valid = 0; br_kind = 2'd0; br_cond = 4'd0; br_reg_zero = 0;
    endtask

    task automatic set_ex(input logic [3:0] nzcv);
        ex_valid = 1; ex_set_flags = 1;
        {ex_negative, ex_zero, ex_carry, ex_overflow} = nzcv;
    endtask

    task automatic set_br(input logic [1:0] kind, input logic [3:0] cond, input logic rz);
        br_valid = 1; br_kind = kind; br_cond = cond; br_reg_zero = rz;
    endtask

    // Called just after a posedge: predict, then compare on the falling edge.
    task automatic apply();
        logic [19:0] e;
        exp_q.push_back({predict(1'b1), predict(1'b0)});
        @(negedge clk);
        e = exp_q.pop_front();
        chk("fwd_ready", rdy1, e[19]);
        chk("fwd_taken", tak1, e[18]);
        chk("fwd_fwd",   fwd1, e[17:14]);
        chk("fwd_q",     q1,   e[13:10]);
        chk("stl_ready", rdy0, e[9]);
        chk("stl_taken", tak0, e[8]);
        chk("stl_fwd",   fwd0, e[7:4]);
        chk("stl_q",     q0,   e[3:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_commit = 4'b0; m_pv = 1'b0; m_pend = 4'b0;
        end else if (!stall) begin
            if (m_pv) m_commit = m_pend;
            m_pv   = ex_valid & ex_set_flags & ~flush;
            m_pend = {ex_negative, ex_zero, ex_carry, ex_overflow};
        end
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; apply(); tick(); reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();

        // Reset held with a flag update on EX
        set_ex(4'b1111);
        apply(); chk("rst_ready", rdy1, 1'b1); chk("rst_q", q1, 4'b0); tick();
        apply(); tick();
        reset = 0; idle(); set_br(2'd3, 4'h0, 1'b0);
        apply(); chk("rst_pend_dropped", rdy0, 1'b1); chk("rst_q_after", q0, 4'b0); tick();

        // Commit latency, unstalled then with one stall cycle
        idle(); set_ex(4'b0100); apply(); tick();
        idle(); apply(); chk("lat_edge1", q1, 4'b0000); tick();
        apply(); chk("lat_edge2", q1, 4'b0100); tick();
        do_reset();
        set_ex(4'b0100); apply(); tick();
        idle(); stall = 1; apply(); tick();
        stall = 0; apply(); chk("lat_stall_edge2", q1, 4'b0000); tick();
        apply(); chk("lat_stall_edge3", q1, 4'b0100); tick();

        // Forwarding of EX flags into B.cond EQ, then killed by flush
        do_reset();
        set_ex(4'b0100); set_br(2'd3, 4'h0, 1'b0);
        apply(); chk("fwd_eq_ready", rdy1, 1'b1); chk("fwd_eq_taken", tak1, 1'b1); tick();
        do_reset();
        set_ex(4'b0100); set_br(2'd3, 4'h0, 1'b0); flush = 1;
        apply(); chk("flush_eq_taken", tak1, 1'b0); tick();
        do_reset();
        set_ex(4'b0100); set_br(2'd3, 4'h0, 1'b0); flush = 1; stall = 1;
        apply(); chk("flush_stall_ready", rdy0, 1'b1); tick();

        // Interlock on B.cond NE, then CBZ bypasses it
        do_reset();
        set_ex(4'b0000); set_br(2'd3, 4'h1, 1'b0);
        apply(); chk("ilk_c0", rdy0, 1'b0); tick();
        ex_valid = 0; ex_set_flags = 0;
        apply(); chk("ilk_c1", rdy0, 1'b0); tick();
        apply(); chk("ilk_c2_ready", rdy0, 1'b1); chk("ilk_c2_taken", tak0, 1'b1); tick();
        do_reset();
        set_ex(4'b0000); set_br(2'd1, 4'h0, 1'b1);
        apply(); chk("cbz_ready", rdy0, 1'b1); chk("cbz_taken", tak0, 1'b1); tick();

        // Full condition table sweep through the forwarding path
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                idle(); set_ex(4'(f)); set_br(2'd3, 4'(c), 1'b0);
                apply();
                if (f == 8 && c == 11) chk("lt_n1v0", tak1, 1'b1);
                if (f == 8 && c == 10) chk("ge_n1v0", tak1, 1'b0);
                if (f == 8 && c == 12) chk("gt_n1v0", tak1, 1'b0);
                if (f == 8 && c == 13) chk("le_n1v0", tak1, 1'b1);
                tick();
            end
        end

        // Back-to-back flag setters
        do_reset();
        set_ex(4'b1000); apply(); chk("b2b_fwd0", fwd1, 4'b1000); tick();
        set_ex(4'b0100); apply(); chk("b2b_fwd1", fwd1, 4'b0100); tick();
        idle(); apply(); chk("b2b_q0", q1, 4'b1000); tick();
        apply(); chk("b2b_q1", q1, 4'b0100); tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 31) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 5) == 0);
            ex_valid     = 1'($urandom_range(0, 1));
            ex_set_flags = 1'($urandom_range(0, 1));
            {ex_negative, ex_zero, ex_carry, ex_overflow} = 4'($urandom_range(0, 15));
            br_valid     = 1'($urandom_range(0, 1));
            br_kind      = 2'($urandom_range(0, 3));
            br_cond      = 4'($urandom_range(0, 15));
            br_reg_zero  = 1'($urandom_range(0, 1));
            apply(); tick();
        end
        reset = 0;

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
